dds_modulator: RTL
==================

# dds_modulator

Parametrised multi-mode direct digital synthesis modulator for the DaDDS transmit path. It is the successor to the fixed 8-bit OOK DDS and adds four modes: OOK, continuous-phase BFSK, BPSK and CW. It has configurable phase, LUT and DAC widths, and symbols are delivered through a valid/ready interface, each lasting a programmable number of clocks. It sits between the UART/config front end and the external parallel DAC.

## Interface
- PHASE_W, 32, phase accumulator and tuning-word width
- LUT_AW, 8, phase bits used for sine lookup (MSBs of accumulator); quarter-wave table has 2^(LUT_AW-2) entries; must be ≥ 3
- DAC_W, 8, DAC sample width (offset binary)
- PER_W, 16, symbol-period counter width

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- cfg_we  in  1  load config registers (accepted only when busy=0)
- cfg_mode  in  2  0=OOK, 1=BFSK, 2=BPSK, 3=CW
- cfg_ftw0  in  PHASE_W  tuning word F0
- cfg_ftw1  in  PHASE_W  tuning word F1 (BFSK only)
- cfg_period  in  PER_W  clocks per symbol; 0 treated as 1
- sym_valid  in  1  symbol offered
- sym_data  in  1  symbol bit
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready
- busy  out  1  state is RUN
- dac  out  DAC_W  sample
- dac_active  out  1  dac carries a modulated sample (aligned with dac)

## Operation
- Config regs (mode, ftw0, ftw1, period) are written on cfg_we only when state is IDLE. cfg_we during RUN is ignored with no side effect.
- FSM states:
  - IDLE: sym_ready=1.
  - RUN: sym_ready=1 only on the last cycle of the current symbol (cnt == period-1).
- Transitions:
  - IDLE→RUN on accept: acc←0, sym←sym_data, cnt←0.
  - RUN, last cycle with accept: sym←sym_data, cnt←0, acc continues (phase-continuous).
  - RUN, last cycle without accept: →IDLE.
  - Otherwise in RUN: cnt increments.
- Accumulator in RUN: acc ← acc + ftw_sel (mod 2^PHASE_W). ftw_sel is ftw1 only in BFSK with sym=1; otherwise ftw0. The update on the boundary cycle uses the outgoing symbol's ftw. In IDLE the accumulator holds.
- Phase word p = acc[PHASE_W-1 -: LUT_AW]. In BPSK with sym=1, p MSB is inverted (180°).
- Quadrant q = p[LUT_AW-1:LUT_AW-2]. Index i = p[LUT_AW-3:0], bitwise-inverted when q[0]=1.
- LUT entry i = round((2^(DAC_W-1)-1)·sin(2π(i+0.5)/2^LUT_AW)), computed at elaboration; unsigned magnitude a.
- Midscale M = 2^(DAC_W-1). Sample = M+a if q[1]=0, else M-1-a. Range is 0..2^DAC_W-1 with no overflow.
- Gate (sample replaced by M, dac_active=0): state IDLE, or OOK with sym=0. CW ignores sym. The accumulator keeps running while gated in OOK.

## Timing
- 2-stage output pipeline. Stage 1 registers quadrant, index and gate from acc/sym/state. Stage 2 registers dac and dac_active. The sample for accumulator value at edge N appears on dac after edge N+2.
- Accept at edge N (IDLE→RUN): dac shows the phase-0 sample after edge N+2.
- Last RUN cycle at edge N: dac returns to M after edge N+2.
- Back-to-back symbols: no gap and no phase discontinuity.
- Reset values:
  - state IDLE, acc 0, cnt 0, sym 0
  - mode 0, ftw0 0, ftw1 0, period 1
  - pipeline gated; dac = M, dac_active 0, busy 0
  - sym_ready 0 while rst=1
- Reset mid-burst: all of the above on the next edge. The in-flight symbol is discarded and dac = M one cycle after the reset edge.
- Simultaneous cfg_we and accept in IDLE: config is written and the symbol is accepted on the same edge. The new config applies to that symbol.

## Test plan
- Reset: assert rst with a burst active -> dac=128, busy=0, dac_active=0 after one edge; sym_ready=1 after release.
- OOK with ftw0=2^24, period=4, symbols 1,0 back-to-back:
  - dac sequence after the 2-cycle latency is 130,133,136,139,128,128,128,128.
  - Then IDLE holds 128 with dac_active low.
- CW with ftw0=2^24, one symbol, period=300:
  - p=63 and p=64 both give 255; p=128 gives 125; p=192 gives 0.
  - Sample 256 wraps back to 130.
- BFSK with ftw0=2^24, ftw1=2^25, period=2, bits 0,1 -> dac 130,133,136,142. Phase is continuous across the boundary.
- BPSK with ftw0=2^24, bit 1 -> first sample 125.
- Handshake and config:
  - sym_ready is high only on the last symbol cycle.
  - cfg_we during RUN leaves ftw unchanged.
  - period=0 behaves as 1.
  - Withholding sym_valid at the boundary -> IDLE, and dac=128 after 2 cycles.

Source files
------------

// File: rtl/dds_modulator.sv
// dds_modulator
// Multi-mode direct digital synthesis modulator (OOK, BFSK, BPSK, CW).
// A phase accumulator driven by a per-symbol tuning word addresses a
// quarter-wave sine table; the sample goes to an offset-binary parallel DAC
// through a two-stage output pipeline.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   cfg_we           load mode/ftw0/ftw1/period (taken only while idle)
//   cfg_mode         0=OOK, 1=BFSK, 2=BPSK, 3=CW
//   cfg_ftw0/1       tuning words (ftw1 used only for BFSK mark symbols)
//   cfg_period       clocks per symbol, 0 behaves as 1
//   sym_valid/data   symbol offer; sym_ready marks when it is taken
//   busy             a symbol is being transmitted
//   dac, dac_active  output sample and its "modulated" qualifier
module dds_modulator #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int DAC_W   = 8,
    parameter int PER_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_ftw0,
    input  logic [PHASE_W-1:0] cfg_ftw1,
    input  logic [PER_W-1:0]   cfg_period,
    input  logic               sym_valid,
    input  logic               sym_data,
    output logic               sym_ready,
    output logic               busy,
    output logic [DAC_W-1:0]   dac,
    output logic               dac_active
);

    localparam int QN = 2 ** (LUT_AW - 2);
    // mode 3 (CW) needs no decode: it never gates and never alters the phase
    localparam logic [1:0] MODE_OOK  = 2'd0;
    localparam logic [1:0] MODE_BFSK = 2'd1;
    localparam logic [1:0] MODE_BPSK = 2'd2;
    localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [DAC_W-1:0] MID     = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0] MID_M1  = {1'b0, {(DAC_W-1){1'b1}}};
    localparam longint PI_Q30 = 64'sd3373259426;  // pi * 2^30

    // Sine magnitude for table entry idx, evaluated in Q30 fixed point with
    // a Taylor series so the table is fully resolved at elaboration.
    function automatic logic [DAC_W-2:0] sine_mag(input int idx);
        longint x_q, x2_q, term_q, sum_q, amp_q;
        x_q    = (PI_Q30 * longint'(2 * idx + 1)) >>> LUT_AW;
        x2_q   = (x_q * x_q) >>> 30;
        term_q = x_q;
        sum_q  = x_q;
        for (int k = 1; k <= 12; k++) begin
            term_q = (-((term_q * x2_q) >>> 30)) / longint'((2 * k) * (2 * k + 1));
            sum_q  = sum_q + term_q;
        end
        amp_q = (sum_q * ((64'sd1 <<< (DAC_W - 1)) - 64'sd1) + 64'sd536870912) >>> 30;
        return amp_q[DAC_W-2:0];
    endfunction

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r;
    logic [PHASE_W-1:0] acc_r;
    logic [PER_W-1:0]   cnt_r;
    logic               sym_r;
    logic [1:0]         mode_r;
    logic [PHASE_W-1:0] ftw0_r;
    logic [PHASE_W-1:0] ftw1_r;
    logic [PER_W-1:0]   period_r;
    logic [1:0]         s1_quad_r;
    logic [LUT_AW-3:0]  s1_idx_r;
    logic               s1_gate_r;
    logic [DAC_W-1:0]   dac_r;
    logic               dac_active_r;

    logic [PER_W-1:0]   per_eff_s;
    logic               last_s;
    logic               ready_s;
    logic               accept_s;
    logic [PHASE_W-1:0] ftw_sel_s;
    logic               flip_s;
    logic [LUT_AW-1:0]  phase_s;
    logic [1:0]         quad_s;
    logic [LUT_AW-3:0]  idx_s;
    logic               gate_s;
    logic [DAC_W-2:0]   mag_s;
    logic [DAC_W-1:0]   sample_s;
    logic [DAC_W-2:0]   lut_s [QN];

    // Quarter-wave table, one elaboration-time constant per entry
    for (genvar g = 0; g < QN; g++) begin : g_lut
        localparam logic [DAC_W-2:0] MAG = sine_mag(g);
        assign lut_s[g] = MAG;
    end

    // Handshake, tuning-word select, phase folding and sample assembly
    always_comb begin
        if (period_r == {PER_W{1'b0}}) begin
            per_eff_s = PER_ONE;
        end else begin
            per_eff_s = period_r;
        end
        last_s = (cnt_r == (per_eff_s - PER_ONE));

        if (rst) begin
            ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = last_s;
        end
        accept_s = sym_valid & ready_s;

        if ((mode_r == MODE_BFSK) && sym_r) begin
            ftw_sel_s = ftw1_r;
        end else begin
            ftw_sel_s = ftw0_r;
        end

        // BPSK mark symbol: flip the phase MSB for a 180 degree shift
        flip_s  = (mode_r == MODE_BPSK) & sym_r;
        phase_s = acc_r[PHASE_W-1 -: LUT_AW] ^ {flip_s, {(LUT_AW-1){1'b0}}};
        quad_s  = phase_s[LUT_AW-1 -: 2];
        // odd quadrants walk the quarter table backwards
        idx_s   = phase_s[LUT_AW-3:0] ^ {(LUT_AW-2){quad_s[0]}};

        if (state_r == ST_IDLE) begin
            gate_s = 1'b1;
        end else if ((mode_r == MODE_OOK) && !sym_r) begin
            gate_s = 1'b1;
        end else begin
            gate_s = 1'b0;
        end

        mag_s = lut_s[s1_idx_r];
        // negative half mirrors around midscale as M-1-a so 0..2^DAC_W-1 is never exceeded
        if (s1_quad_r[1] == 1'b0) begin
            sample_s = MID + {1'b0, mag_s};
        end else begin
            sample_s = MID_M1 - {1'b0, mag_s};
        end
    end

    // Control FSM: config capture, symbol sequencing and phase accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            acc_r    <= {PHASE_W{1'b0}};
            cnt_r    <= {PER_W{1'b0}};
            sym_r    <= 1'b0;
            mode_r   <= 2'd0;
            ftw0_r   <= {PHASE_W{1'b0}};
            ftw1_r   <= {PHASE_W{1'b0}};
            period_r <= PER_ONE;
        end else begin
            if ((state_r == ST_IDLE) && cfg_we) begin
                mode_r   <= cfg_mode;
                ftw0_r   <= cfg_ftw0;
                ftw1_r   <= cfg_ftw1;
                period_r <= cfg_period;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RUN;
                        acc_r   <= {PHASE_W{1'b0}};
                        sym_r   <= sym_data;
                        cnt_r   <= {PER_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    // boundary cycle still advances with the outgoing symbol's word
                    acc_r <= acc_r + ftw_sel_s;
                    if (last_s) begin
                        cnt_r <= {PER_W{1'b0}};
                        if (accept_s) begin
                            sym_r <= sym_data;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + PER_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output pipeline: stage 1 holds folded phase and gate, stage 2 the sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_quad_r    <= 2'd0;
            s1_idx_r     <= {(LUT_AW-2){1'b0}};
            s1_gate_r    <= 1'b1;
            dac_r        <= MID;
            dac_active_r <= 1'b0;
        end else begin
            s1_quad_r    <= quad_s;
            s1_idx_r     <= idx_s;
            s1_gate_r    <= gate_s;
            dac_r        <= s1_gate_r ? MID : sample_s;
            dac_active_r <= ~s1_gate_r;
        end
    end

    assign sym_ready  = ready_s;
    assign busy       = (state_r == ST_RUN);
    assign dac        = dac_r;
    assign dac_active = dac_active_r;

endmodule
